// File: rtl/cordic_rom_loader.sv
// cordic_rom_loader
//
// Loads a CORDIC coefficient table from a byte stream. Every six accepted
// bytes are packed MSB first into one 48-bit word, which is written to the
// table with a one-cycle strobe. After ENTRIES words, one more byte is
// taken as a checksum and compared with the 8-bit running sum of all
// payload bytes.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   start      begins a session from IDLE or DONE, ignored while busy
//   din        input byte stream
//   din_valid  din holds a valid byte
//   din_ready  loader accepts din this cycle
//   wen        one-cycle table write strobe
//   index_wri  table write address, holds the last written value
//   D          table write data, holds the last written value
//   busy       session in progress
//   done       session finished, held until the next start
//   err        checksum mismatch on the last session, valid while done=1
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start, stream not accepted
// S_LOAD  | accepting payload bytes into the assembly register
// S_WRITE | single-cycle table write of the assembled word
// S_CHECK | waiting for the checksum byte
// S_DONE  | session complete, err valid, waiting for start

module cordic_rom_loader #(
    parameter int ENTRIES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic        wen,
    output logic [5:0]  index_wri,
    output logic [47:0] D,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(ENTRIES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  word_idx;
    logic [2:0]  byte_cnt;
    logic [7:0]  csum;
    // Only the first five bytes of a word are buffered; the sixth goes
    // straight from din into D.
    logic [39:0] shift_reg;
    logic        session_start;
    logic        word_last_byte;

    assign session_start  = ((state == S_IDLE) || (state == S_DONE)) && start;
    assign word_last_byte = (byte_cnt == 3'd5);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        din_ready = 1'b0;
        busy      = 1'b0;
        wen       = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                din_ready = 1'b1;
                busy      = 1'b1;
                if (din_valid && word_last_byte) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                wen  = 1'b1;
                busy = 1'b1;
                if (word_idx == LAST_IDX) begin
                    state_nxt = S_CHECK;
                end else begin
                    state_nxt = S_LOAD;
                end
            end
            S_CHECK: begin
                din_ready = 1'b1;
                busy      = 1'b1;
                if (din_valid) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            word_idx  <= '0;
            byte_cnt  <= '0;
            csum      <= '0;
            shift_reg <= '0;
            index_wri <= '0;
            D         <= '0;
            err       <= 1'b0;
        end else begin
            if (session_start) begin
                word_idx <= '0;
                byte_cnt <= '0;
                csum     <= '0;
                err      <= 1'b0;
            end

            if ((state == S_LOAD) && din_valid) begin
                shift_reg <= {shift_reg[31:0], din};
                csum      <= csum + din;
                if (word_last_byte) begin
                    byte_cnt  <= '0;
                    // Latch address and data on entry to S_WRITE so both
                    // hold the last written values afterwards.
                    D         <= {shift_reg, din};
                    index_wri <= word_idx;
                end else begin
                    byte_cnt <= byte_cnt + 3'd1;
                end
            end

            if (state == S_WRITE) begin
                word_idx <= word_idx + 6'd1;
            end

            if ((state == S_CHECK) && din_valid) begin
                err <= (din != csum);
            end
        end
    end

endmodule

// File: tb/tb_cordic_rom_loader.sv
// tb_cordic_rom_loader
//
// Directed bench for cordic_rom_loader. One instance uses the default
// 64-entry table, a second uses ENTRIES=1. Table writes are logged on the
// falling edge and compared against hand-built word/checksum streams.

module tb_cordic_rom_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic        wen;
    logic [5:0]  index_wri;
    logic [47:0] D;
    logic        busy;
    logic        done;
    logic        err;

    logic        start1;
    logic [7:0]  din1;
    logic        din_valid1;
    logic        din_ready1;
    logic        wen1;
    logic [5:0]  index_wri1;
    logic [47:0] d1;
    logic        busy1;
    logic        done1;
    logic        err1;

    always #5 clk = ~clk;

    cordic_rom_loader u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .wen       (wen),
        .index_wri (index_wri),
        .D         (D),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    cordic_rom_loader #(.ENTRIES(1)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start1),
        .din       (din1),
        .din_valid (din_valid1),
        .din_ready (din_ready1),
        .wen       (wen1),
        .index_wri (index_wri1),
        .D         (d1),
        .busy      (busy1),
        .done      (done1),
        .err       (err1)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [5:0]  wr_idx [$];
    logic [47:0] wr_d   [$];
    int          wr_cyc [$];
    int          rdy_on_write = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wen) begin
            wr_idx.push_back(index_wri);
            wr_d.push_back(D);
            wr_cyc.push_back(cyc);
            if (din_ready) rdy_on_write <= rdy_on_write + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int budget;
        int idle;
        if (gaps) begin
            idle = 0;
            while (($urandom_range(0, 1) == 1) && (idle < 4)) begin
                din_valid = 1'b0;
                step();
                idle++;
            end
        end
        din       = b;
        din_valid = 1'b1;
        budget    = 20;
        while (!din_ready && (budget > 0)) begin
            step();
            budget--;
        end
        if (budget == 0) chk("ready_timeout", {63'd0, din_ready}, 64'd1);
        step();
    endtask

    task automatic start_session();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("done_cleared", {63'd0, done}, 64'd0);
        chk("err_cleared", {63'd0, err}, 64'd0);
    endtask

    task automatic run_session(input string name, input bit gaps, input bit bad, input bit poke);
        int         base;
        int         rdy0;
        int         n_wr;
        logic [7:0] kb;
        logic [7:0] sum;
        base = wr_idx.size();
        rdy0 = rdy_on_write;
        sum  = 8'h00;
        start_session();
        for (int k = 0; k < 64; k++) begin
            kb = 8'(k);
            for (int j = 0; j < 6; j++) begin
                if (poke) start = j[0];
                send_byte(kb, gaps);
                sum = sum + kb;
            end
        end
        start = 1'b0;
        send_byte(bad ? (sum ^ 8'h01) : sum, gaps);
        din_valid = 1'b0;
        chk({name, "_done"}, {63'd0, done}, 64'd1);
        chk({name, "_busy"}, {63'd0, busy}, 64'd0);
        chk({name, "_err"}, {63'd0, err}, {63'd0, bad});
        chk({name, "_ready_done"}, {63'd0, din_ready}, 64'd0);
        n_wr = wr_idx.size() - base;
        chk({name, "_wr_count"}, 64'(n_wr), 64'd64);
        for (int i = 0; i < 64; i++) begin
            if (i < n_wr) begin
                kb = 8'(i);
                chk({name, "_idx"}, 64'(wr_idx[base + i]), 64'(i));
                chk({name, "_data"}, 64'(wr_d[base + i]), 64'({6{kb}}));
                if (!gaps && (i > 0))
                    chk({name, "_spacing"}, 64'(wr_cyc[base + i] - wr_cyc[base + i - 1]), 64'd7);
            end
        end
        chk({name, "_ready_on_write"}, 64'(rdy_on_write - rdy0), 64'd0);
        repeat (3) step();
        chk({name, "_done_held"}, {63'd0, done}, 64'd1);
        chk({name, "_err_held"}, {63'd0, err}, {63'd0, bad});
        chk({name, "_idx_held"}, 64'(index_wri), 64'd63);
        chk({name, "_d_held"}, 64'(D), 64'h3F3F3F3F3F3F);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_wen"}, {63'd0, wen}, 64'd0);
        chk({name, "_din_ready"}, {63'd0, din_ready}, 64'd0);
        chk({name, "_index"}, 64'(index_wri), 64'd0);
        chk({name, "_D"}, 64'(D), 64'd0);
        chk({name, "_busy"}, {63'd0, busy}, 64'd0);
        chk({name, "_done"}, {63'd0, done}, 64'd0);
        chk({name, "_err"}, {63'd0, err}, 64'd0);
    endtask

    logic [7:0] b1 [6] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        logic [7:0] sum1;
        reset      = 1'b0;
        start      = 1'b0;
        din        = 8'h00;
        din_valid  = 1'b0;
        start1     = 1'b0;
        din1       = 8'h00;
        din_valid1 = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b1;
        step();

        // idle ignores the stream
        din_valid = 1'b1;
        din       = 8'h5A;
        step();
        chk("idle_ready", {63'd0, din_ready}, 64'd0);
        chk("idle_busy", {63'd0, busy}, 64'd0);
        din_valid = 1'b0;

        run_session("full", 1'b0, 1'b0, 1'b0);
        run_session("badsum", 1'b0, 1'b1, 1'b0);
        run_session("gaps", 1'b1, 1'b0, 1'b0);
        run_session("poke", 1'b0, 1'b0, 1'b1);

        // abort after 100 accepted bytes
        start_session();
        for (int i = 0; i < 100; i++) send_byte(8'(i / 6), 1'b0);
        chk("pre_abort_idx", 64'(index_wri), 64'd15);
        reset = 1'b0;
        step();
        check_all_zero("abort");
        reset     = 1'b1;
        din_valid = 1'b0;
        base      = wr_idx.size();
        repeat (10) step();
        chk("abort_no_wen", 64'(wr_idx.size() - base), 64'd0);
        run_session("restart", 1'b0, 1'b0, 1'b0);

        // single-entry table
        sum1 = 8'h00;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int j = 0; j < 6; j++) begin
            din1       = b1[j];
            din_valid1 = 1'b1;
            sum1       = sum1 + b1[j];
            step();
        end
        chk("e1_wen", {63'd0, wen1}, 64'd1);
        chk("e1_idx", 64'(index_wri1), 64'd0);
        chk("e1_data", 64'(d1), 64'h0123456789AB);
        chk("e1_ready_write", {63'd0, din_ready1}, 64'd0);
        din1 = sum1;
        step();
        chk("e1_ready_check", {63'd0, din_ready1}, 64'd1);
        chk("e1_no_wen", {63'd0, wen1}, 64'd0);
        step();
        din_valid1 = 1'b0;
        chk("e1_done", {63'd0, done1}, 64'd1);
        chk("e1_err", {63'd0, err1}, 64'd0);
        chk("e1_busy", {63'd0, busy1}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
